cordic: RTL and testbench



---
 rtl/cordic.sv | 154 +++++++++++++++
 tb/tb_cordic.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cordic.sv
// -----------------------------------------------------------------------------
// cordic -- iterative rotation-mode CORDIC producing cos/sin of an angle.
//
// A pulse on init loads the angle and starts N_ITER micro-rotations, one per
// clock. A final cycle copies the rotated vector into the output registers and
// raises done. done and the outputs hold until the next accepted init.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   target_angle  signed Q2.16 angle in radians, legal -pi/2..+pi/2
//   init          start strobe; accepted in any state (restarts a run)
//   cosine        signed Q2.16 cos(target_angle), registered
//   sine          signed Q2.16 sin(target_angle), registered
//   done          result valid; cleared by the next accepted init
// -----------------------------------------------------------------------------
module cordic #(
    parameter int N_ITER = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] target_angle,
    input  logic        init,
    output logic [17:0] cosine,
    output logic [17:0] sine,
    output logic        done
);

    // x/y carry extra fraction bits below Q2.16 so the per-iteration shift
    // truncation does not pile up in the final 18-bit result.
    localparam int GUARD = 4;
    localparam int XY_W  = 18 + GUARD;

    // CORDIC gain compensation K = 0.6072529 (39797 in Q2.16), pre-scaled
    // into the guarded x/y format.
    localparam logic signed [XY_W-1:0] K_INIT = 22'sd636752;

    localparam logic [4:0] LAST_ITER = 5'(N_ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t                  state_q;
    logic signed [XY_W-1:0]  x_q, y_q;
    logic signed [17:0]      z_q;
    logic [4:0]              i_q;
    logic [17:0]             cos_q, sin_q;
    logic                    done_q;

    logic signed [XY_W-1:0]  x_d, y_d;
    logic signed [17:0]      z_d;
    logic signed [XY_W-1:0]  x_sh, y_sh;
    logic signed [17:0]      atan_i;

    // round(atan(2^-i) * 65536), Q2.16 radians
    function automatic logic signed [17:0] atan_lut(input logic [4:0] idx);
        logic signed [17:0] v;
        case (idx)
            5'd0:    v = 18'sd51472;
            5'd1:    v = 18'sd30386;
            5'd2:    v = 18'sd16055;
            5'd3:    v = 18'sd8150;
            5'd4:    v = 18'sd4091;
            5'd5:    v = 18'sd2047;
            5'd6:    v = 18'sd1024;
            5'd7:    v = 18'sd512;
            5'd8:    v = 18'sd256;
            5'd9:    v = 18'sd128;
            5'd10:   v = 18'sd64;
            5'd11:   v = 18'sd32;
            5'd12:   v = 18'sd16;
            5'd13:   v = 18'sd8;
            5'd14:   v = 18'sd4;
            5'd15:   v = 18'sd2;
            default: v = 18'sd0;
        endcase
        return v;
    endfunction

    // Drop the guard bits: arithmetic shift right then keep 18 bits, i.e.
    // two's-complement truncation toward minus infinity.
    function automatic logic [17:0] trunc_out(input logic signed [XY_W-1:0] v);
        return v[XY_W-1:GUARD];
    endfunction

    // One micro-rotation. Direction follows the sign of the residual angle.
    always_comb begin
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_i = atan_lut(i_q);
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        if (!z_q[17]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            done_q  <= 1'b0;
        end else if (init) begin
            // Accepted in every state: an in-flight run is simply discarded.
            state_q <= RUN;
            x_q     <= K_INIT;
            y_q     <= '0;
            z_q     <= signed'(target_angle);
            i_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    i_q <= i_q + 5'd1;
                    if (i_q == LAST_ITER) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    cos_q   <= trunc_out(x_q);
                    sin_q   <= trunc_out(y_q);
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cosine = cos_q;
    assign sine   = sin_q;
    assign done   = done_q;

endmodule

// File: tb/tb_cordic.sv
module tb_cordic;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] target_angle;
    logic        init;
    logic [17:0] cosine;
    logic [17:0] sine;
    logic        done;

    always #5 clk = ~clk;

    cordic #(.N_ITER(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .target_angle (target_angle),
        .init         (init),
        .cosine       (cosine),
        .sine         (sine),
        .done         (done)
    );

    typedef struct {
        int    c;
        int    s;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic int ref_val(input int ang, input bit is_sin);
        real a;
        real v;
        a = real'(ang) / 65536.0;
        v = is_sin ? $sin(a) : $cos(a);
        return $rtoi($floor(v * 65536.0 + 0.5));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int obs, input int expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int expv);
        int diff;
        bit ok;
        diff = obs - expv;
        ok   = (diff >= -8) && (diff <= 8);
        tests_run++;
        assert (ok === 1'b1) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d (+/-8)", tag, obs, expv);
        end
    endtask

    // Drive one init pulse and record the expected result.
    task automatic start(input int ang, input string tag);
        exp_t e;
        e.c   = ref_val(ang, 1'b0);
        e.s   = ref_val(ang, 1'b1);
        e.tag = tag;
        sb.push_back(e);
        target_angle = 18'(ang);
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    // Wait (bounded) for done, check latency, pop and compare the result.
    task automatic finish_run();
        int   n;
        exp_t e;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check_eq("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, "_latency"}, n, 17);
            check_tol({e.tag, "_cos"}, int'($signed(cosine)), e.c);
            check_tol({e.tag, "_sin"}, int'($signed(sine)), e.s);
        end
    endtask

    initial begin
        int prev_c;
        int prev_s;
        bit early;

        // Reset held with init also high: reset must win.
        reset        = 1'b1;
        init         = 1'b1;
        target_angle = 18'(78643);
        tick();
        tick();
        check_eq("rst_cos", int'(cosine), 0);
        check_eq("rst_sin", int'(sine), 0);
        check_eq("rst_done", int'(done), 0);
        reset = 1'b0;
        init  = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) early = 1'b1;
        end
        check_eq("rst_wins_no_done", int'(early), 0);

        // 1.2 rad
        start(78643, "a1p2");
        finish_run();
        prev_c = int'($signed(cosine));
        prev_s = int'($signed(sine));
        tick();
        tick();
        tick();
        check_eq("hold_done", int'(done), 1);
        check_eq("hold_cos", int'($signed(cosine)), prev_c);
        check_eq("hold_sin", int'($signed(sine)), prev_s);

        // 0 rad; the init edge clears done but leaves outputs alone
        start(0, "a0");
        check_eq("init_clears_done", int'(done), 0);
        check_eq("init_keeps_cos", int'($signed(cosine)), prev_c);
        finish_run();

        start(-78643, "am1p2");
        finish_run();
        start(102944, "api2");
        finish_run();
        start(51472, "api4");
        finish_run();
        start(-102944, "ampi2");
        finish_run();

        // Reset sampled 5 edges after init aborts the run
        start(78643, "abort_rst");
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_back());
        check_eq("midrst_cos", int'(cosine), 0);
        check_eq("midrst_sin", int'(sine), 0);
        check_eq("midrst_done", int'(done), 0);
        early = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) early = 1'b1;
        end
        check_eq("midrst_idle", int'(early), 0);
        start(32768, "after_rst");
        finish_run();

        // Restart: second init at edge 8 of a 1.2 rad run
        start(78643, "abort_restart");
        early = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (done) early = 1'b1;
        end
        void'(sb.pop_back());
        start(0, "restart0");
        if (done) early = 1'b1;
        check_eq("restart_no_done", int'(early), 0);
        finish_run();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
